// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter: decrements on enable, pulses zero at terminal count,
// then stops or reloads from the last loaded start value.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             zero
);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // State, datapath and zero pulse share one register block; busy tracks state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            value      <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            zero       <= 1'b0;
        end else begin
            zero <= 1'b0;
            if (load) begin
                value      <= load_value;
                reload_reg <= load_value;
                if (load_value != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN, PAUSED: begin
                        if (enable) begin
                            // Resume from PAUSED counts on the same edge.
                            state <= RUN;
                            busy  <= 1'b1;
                            if (value == WIDTH'(1)) begin
                                zero <= 1'b1;
                                if (auto_reload) begin
                                    value <= reload_reg;
                                end else begin
                                    value <= '0;
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                value <= value - WIDTH'(1);
                            end
                        end else begin
                            state <= PAUSED;
                            busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter.
module tb_down_counter;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             zero;

    int passed = 0;
    int total  = 0;

    down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .value       (value),
        .busy        (busy),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] exp_value,
                         input logic exp_busy, input logic exp_zero);
        logic [WIDTH+1:0] obs;
        logic [WIDTH+1:0] exp;
        obs = {value, busy, zero};
        exp = {exp_value, exp_busy, exp_zero};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed value=%0d busy=%0b zero=%0b, expected value=%0d busy=%0b zero=%0b",
                    tag, value, busy, zero, exp_value, exp_busy, exp_zero);
    endtask

    initial begin
        reset       = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        enable      = 1'b1;
        auto_reload = 1'b0;
        #3;
        check("reset_state", 8'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check("idle_after_reset", 8'd0, 1'b0, 1'b0);

        // One-shot count from 5
        load = 1'b1; load_value = 8'd5;
        step();
        load = 1'b0;
        check("load5", 8'd5, 1'b1, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            step();
            check("count5", WIDTH'(i), 1'b1, 1'b0);
        end
        step();
        check("terminal5", 8'd0, 1'b0, 1'b1);
        step();
        check("stopped5", 8'd0, 1'b0, 1'b0);

        // Auto-reload period 3
        auto_reload = 1'b1;
        load = 1'b1; load_value = 8'd3;
        step();
        load = 1'b0;
        check("load3", 8'd3, 1'b1, 1'b0);
        step(); check("ar_2a", 8'd2, 1'b1, 1'b0);
        step(); check("ar_1a", 8'd1, 1'b1, 1'b0);
        step(); check("ar_reload_a", 8'd3, 1'b1, 1'b1);
        step(); check("ar_2b", 8'd2, 1'b1, 1'b0);
        step(); check("ar_1b", 8'd1, 1'b1, 1'b0);
        step(); check("ar_reload_b", 8'd3, 1'b1, 1'b1);
        step(); check("ar_2c", 8'd2, 1'b1, 1'b0);
        auto_reload = 1'b0;
        step(); check("ar_1c", 8'd1, 1'b1, 1'b0);
        step(); check("ar_stop", 8'd0, 1'b0, 1'b1);
        step(); check("ar_stopped", 8'd0, 1'b0, 1'b0);

        // Pause at 4 for three cycles
        load = 1'b1; load_value = 8'd6;
        step();
        load = 1'b0;
        check("load6", 8'd6, 1'b1, 1'b0);
        step(); check("p_5", 8'd5, 1'b1, 1'b0);
        step(); check("p_4", 8'd4, 1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("paused_hold", 8'd4, 1'b1, 1'b0);
        end
        enable = 1'b1;
        step(); check("resume_3", 8'd3, 1'b1, 1'b0);

        // Load of zero interrupts a run
        load = 1'b1; load_value = 8'd0;
        step();
        load = 1'b0;
        check("load0", 8'd0, 1'b0, 1'b0);
        step(); check("load0_idle", 8'd0, 1'b0, 1'b0);

        // Load collides with terminal count
        load = 1'b1; load_value = 8'd1;
        step();
        check("load1", 8'd1, 1'b1, 1'b0);
        load_value = 8'd9;
        step();
        load = 1'b0;
        check("load_over_tc", 8'd9, 1'b1, 1'b0);
        step(); check("after_collide", 8'd8, 1'b1, 1'b0);

        // Asynchronous reset mid-count
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 8'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step(); check("post_reset_idle_a", 8'd0, 1'b0, 1'b0);
        step(); check("post_reset_idle_b", 8'd0, 1'b0, 1'b0);

        // Terminal count reached directly out of PAUSED
        load = 1'b1; load_value = 8'd2;
        step();
        load = 1'b0;
        check("load2", 8'd2, 1'b1, 1'b0);
        step(); check("p2_1", 8'd1, 1'b1, 1'b0);
        enable = 1'b0;
        step(); check("p2_hold", 8'd1, 1'b1, 1'b0);
        enable = 1'b1;
        step(); check("p2_resume_tc", 8'd0, 1'b0, 1'b1);

        // Maximum load value
        load = 1'b1; load_value = 8'd255;
        step();
        load = 1'b0;
        check("load_max", 8'd255, 1'b1, 1'b0);
        step(); check("max_dec", 8'd254, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable down-counter/timer, the counting-down counterpart of the team's free-running up-counter. It is loaded with a start value and decrements once per enabled clock. On reaching terminal count it emits a one-cycle `zero` pulse, then either stops or reloads automatically. It is used wherever the design needs a programmable delay or a periodic tick rather than a running count value.

## Interface
- `WIDTH`, default 8: width of the count and load value.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  load request, sampled on the rising `clk` edge.
- `load_value`  in  `WIDTH`  start value, captured when `load` is high.
- `enable`  in  1  count enable; decrement occurs only when high.
- `auto_reload`  in  1  at terminal count: 1 = reload from the stored start value, 0 = stop.
- `value`  out  `WIDTH`  current count, registered.
- `busy`  out  1  high while in RUN or PAUSED.
- `zero`  out  1  one-cycle pulse at terminal count, registered.

## Operation
- FSM states: IDLE, RUN, PAUSED. An internal `reload_reg` (`WIDTH` bits) holds the last loaded value.
- Reset (`reset`=0), applied asynchronously at any time, including mid-count:
  - state → IDLE; `value`=0, `reload_reg`=0, `busy`=0, `zero`=0.
  - All of these hold until the first rising edge after `reset` returns high.
- `load`=1 has priority over everything except reset, in every state:
  - `value` ← `load_value` and `reload_reg` ← `load_value`.
  - Next state is RUN if `load_value` ≠ 0, otherwise IDLE.
  - `zero`=0 in both cases.
- IDLE: `value` holds and `enable` is ignored.
- RUN, `enable`=1, `value` > 1: `value` ← `value` − 1.
- RUN, `enable`=1, `value` = 1 (terminal count): `zero` ← 1 for exactly one cycle.
  - `auto_reload`=1: `value` ← `reload_reg`, stay in RUN.
  - `auto_reload`=0: `value` ← 0, go to IDLE, `busy` ← 0.
  - `auto_reload` is sampled only on the terminal-count edge.
- RUN, `enable`=0: go to PAUSED; `value` holds.
- PAUSED, `enable`=1: go to RUN and apply the RUN decrement/terminal rule on that same edge. Resume costs no cycle.
- PAUSED, `enable`=0: hold.
- `load` on the same edge as terminal count: the load wins, `zero` stays 0 and `value` = `load_value`.
- Arithmetic: unsigned, modulo 2^`WIDTH`. `value` never underflows, because 0 is only reachable via terminal count, a load of 0, or reset.
- `load_value` = 2^`WIDTH`−1 is legal and gives the maximum period.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Load latency: `value` = `load_value` and `busy` = 1 one edge after `load` is sampled.
- Period with `enable` held high:
  - Non-reload: `zero` pulses N edges after the load edge, coincident with `value` becoming 0.
  - Auto-reload: `zero` pulses every N edges, coincident with `value` returning to N.
- `busy` is 1 in RUN and PAUSED. It falls on the same edge that `zero` rises in a non-reload terminal count.

## Structure
- Shared package `down_counter_pkg`:
  - state typedef: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10.
  - `WIDTH` default constant.
- Single module with no sub-module. It contains:
  - one state register;
  - next-state logic;
  - the `value`/`reload_reg` datapath;
  - the `zero` register.

## Test plan
- Assert `reset`=0 mid-count asynchronously (between edges) → `value`=0, `busy`=0, `zero`=0 immediately. After release, the counter stays in IDLE until the next load.
- Load 5 with `enable`=1, `auto_reload`=0 → `value` 5,4,3,2,1,0 on successive edges. `zero`=1 only in the cycle `value`=0; `busy` falls on the same edge and `value` stays 0.
- Load 3 with `auto_reload`=1 and `enable`=1 → `value` 3,2,1,3,2,1,3… and `zero` pulses every 3rd cycle, coincident with `value`=3. Setting `auto_reload`=0 before the next terminal count → stop at 0.
- Load 6, drop `enable` for 3 cycles when `value`=4 → `value` holds 4 and `busy`=1. Re-assert `enable` → 3 on the first edge.
- Load 0 → `value`=0, `busy`=0, no `zero` pulse.
- Load 9 on the same edge as a terminal count from 1 → `value`=9, `busy`=1, `zero`=0.
